// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Scans cyclically starting just after 'last'; with exclude set, 'last' itself
  // can never win even if it is still requesting.
  function automatic rr_pick_t next_rr(input logic [NUM_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   last,
                                       input logic               exclude);
    rr_pick_t         pick;
    logic [IDX_W-1:0] cand;
    pick = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!pick.found && req[cand] && !(exclude && (cand == last))) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder2to4.sv
// Enabled 2-to-4 one-hot decoder; all outputs low when en is low.
module decoder2to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) begin
      y[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold, saturating hold counter
// and timeout preemption when another master is waiting.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter  int MAX_HOLD = 8,
  localparam int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               preempt,
  output logic [CNT_W-1:0]   hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_SAT =
    (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;
  logic             pre_d;
  logic [CNT_W-1:0] hold_d;
  rr_pick_t         pick_any;
  rr_pick_t         pick_other;
  logic             timeout;

  assign timeout = (MAX_HOLD > 0) && (hold_cnt == HOLD_SAT);

  // pick_other doubles as the "someone else is waiting" flag while granted,
  // since last_q always equals the owner in GRANT.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = gnt_idx;
    valid_d    = gnt_valid;
    pre_d      = 1'b0;
    hold_d     = hold_cnt;
    pick_any   = next_rr(req, last_q, 1'b0);
    pick_other = next_rr(req, last_q, 1'b1);

    case (state_q)
      IDLE: begin
        if (pick_any.found) begin
          state_d = GRANT;
          idx_d   = pick_any.idx;
          last_d  = pick_any.idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          if (pick_any.found) begin
            idx_d  = pick_any.idx;
            last_d = pick_any.idx;
            hold_d = '0;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (timeout && pick_other.found) begin
          idx_d  = pick_other.idx;
          last_d = pick_other.idx;
          hold_d = '0;
          pre_d  = 1'b1;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_d = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= IDX_W'(NUM_REQ - 1);
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      preempt   <= pre_d;
      hold_cnt  <= hold_d;
    end
  end

  decoder2to4 u_dec (
    .en  (gnt_valid),
    .sel (gnt_idx),
    .y   (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: a MAX_HOLD=8 and a MAX_HOLD=0 instance checked every
// cycle against an integer-level arbitration model, plus directed literal checks.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req0;

  logic [3:0] gnt8, gnt0;
  logic [1:0] idx8, idx0;
  logic       v8, v0, p8, p0;
  logic [3:0] hc8;
  logic [0:0] hc0;

  int checks = 0;
  int errors = 0;
  int pre0_seen = 0;

  int m_owner [2] = '{-1, -1};
  int m_idx   [2] = '{0, 0};
  int m_hold  [2] = '{0, 0};
  int m_last  [2] = '{3, 3};
  int m_pre   [2] = '{0, 0};
  bit model_live = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt8), .gnt_idx(idx8),
    .gnt_valid(v8), .preempt(p8), .hold_cnt(hc8)
  );

  rr_arbiter4 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .gnt(gnt0), .gnt_idx(idx0),
    .gnt_valid(v0), .preempt(p0), .hold_cnt(hc0)
  );

  // First requesting master after 'from' in cyclic order, never 'skip'; -1 if none.
  function automatic int scan(input logic [3:0] r, input int from, input int skip);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (r[c] === 1'b1 && c != skip) return c;
    end
    return -1;
  endfunction

  // Model: unit 0 is MAX_HOLD=8 (counter caps at 7), unit 1 is MAX_HOLD=0 (1-bit cap 1).
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic [3:0] r;
      int mh, cap, w;
      r   = (u == 0) ? req : req0;
      mh  = (u == 0) ? 8 : 0;
      cap = (u == 0) ? 7 : 1;
      m_pre[u] = 0;
      if (rst) begin
        m_owner[u] = -1; m_idx[u] = 0; m_hold[u] = 0; m_last[u] = 3;
      end else if (m_owner[u] < 0 || r[m_owner[u]] !== 1'b1) begin
        w = scan(r, m_last[u], -1);
        if (w >= 0) begin
          m_owner[u] = w; m_idx[u] = w; m_last[u] = w; m_hold[u] = 0;
        end else begin
          m_owner[u] = -1; m_hold[u] = 0;
        end
      end else begin
        w = scan(r, m_owner[u], m_owner[u]);
        if (mh > 0 && m_hold[u] == mh - 1 && w >= 0) begin
          m_owner[u] = w; m_idx[u] = w; m_last[u] = w; m_hold[u] = 0; m_pre[u] = 1;
        end else if (m_hold[u] < cap) begin
          m_hold[u] = m_hold[u] + 1;
        end
      end
    end
    if (rst) model_live = 1'b1;
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic checkUnit(input string name, input int u, input logic [3:0] g,
                           input logic [1:0] i, input logic v, input logic p,
                           input logic [31:0] h);
    logic [31:0] eg;
    eg = (m_owner[u] >= 0) ? (32'd1 << m_idx[u]) : 32'd0;
    checkVal({name, " gnt"},       32'(g), eg);
    checkVal({name, " gnt_idx"},   32'(i), 32'(m_idx[u]));
    checkVal({name, " gnt_valid"}, 32'(v), (m_owner[u] >= 0) ? 32'd1 : 32'd0);
    checkVal({name, " preempt"},   32'(p), 32'(m_pre[u]));
    checkVal({name, " hold_cnt"},  h,      32'(m_hold[u]));
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      checkUnit("model8", 0, gnt8, idx8, v8, p8, 32'(hc8));
      checkUnit("model0", 1, gnt0, idx0, v0, p0, 32'(hc0));
      if (p0 === 1'b1) pre0_seen++;
    end
  end

  task automatic checkOutput(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                             input logic ev, input logic ep, input logic [3:0] eh);
    checkVal({tag, " gnt"},       32'(gnt8), 32'(eg));
    checkVal({tag, " gnt_idx"},   32'(idx8), 32'(ei));
    checkVal({tag, " gnt_valid"}, 32'(v8),   32'(ev));
    checkVal({tag, " preempt"},   32'(p8),   32'(ep));
    checkVal({tag, " hold_cnt"},  32'(hc8),  32'(eh));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input int n);
    req = r;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    req0 = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 4'd0);

    // All four requesting: rotation every 8 grant cycles
    applyStimulus(4'b1111, 1); checkOutput("all first",  4'b0001, 2'd0, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b1111, 7); checkOutput("all hold7",  4'b0001, 2'd0, 1'b1, 1'b0, 4'd7);
    applyStimulus(4'b1111, 1); checkOutput("all pre1",   4'b0010, 2'd1, 1'b1, 1'b1, 4'd0);
    applyStimulus(4'b1111, 8); checkOutput("all pre2",   4'b0100, 2'd2, 1'b1, 1'b1, 4'd0);
    applyStimulus(4'b1111, 8); checkOutput("all pre3",   4'b1000, 2'd3, 1'b1, 1'b1, 4'd0);
    applyStimulus(4'b1111, 8); checkOutput("all pre0",   4'b0001, 2'd0, 1'b1, 1'b1, 4'd0);

    // Lone requester saturates, then preempted by a late arrival
    doReset();
    applyStimulus(4'b0100, 1);  checkOutput("solo first", 4'b0100, 2'd2, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b0100, 19); checkOutput("solo sat",   4'b0100, 2'd2, 1'b1, 1'b0, 4'd7);
    applyStimulus(4'b0101, 1);  checkOutput("solo pre",   4'b0001, 2'd0, 1'b1, 1'b1, 4'd0);

    // Release handover with no bubble, then release to empty keeps gnt_idx
    doReset();
    applyStimulus(4'b0011, 1); checkOutput("hand first", 4'b0001, 2'd0, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b0011, 2); checkOutput("hand hold",  4'b0001, 2'd0, 1'b1, 1'b0, 4'd2);
    applyStimulus(4'b0010, 1); checkOutput("hand over",  4'b0010, 2'd1, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b0000, 1); checkOutput("hand idle",  4'b0000, 2'd1, 1'b0, 1'b0, 4'd0);

    doReset();
    applyStimulus(4'b0001, 2); checkOutput("empty hold", 4'b0001, 2'd0, 1'b1, 1'b0, 4'd1);
    applyStimulus(4'b0000, 1); checkOutput("empty idle", 4'b0000, 2'd0, 1'b0, 1'b0, 4'd0);

    // Reset mid-grant restores the pointer so master 0 wins over master 3
    doReset();
    applyStimulus(4'b1000, 1); checkOutput("mid first",  4'b1000, 2'd3, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b1000, 3); checkOutput("mid hold3",  4'b1000, 2'd3, 1'b1, 1'b0, 4'd3);
    rst = 1'b1;
    @(negedge clk);            checkOutput("mid reset",  4'b0000, 2'd0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    applyStimulus(4'b1001, 1); checkOutput("mid after",  4'b0001, 2'd0, 1'b1, 1'b0, 4'd0);

    // Owner drops exactly when the timeout would fire: release wins
    doReset();
    applyStimulus(4'b0011, 1); checkOutput("coll first", 4'b0001, 2'd0, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b0011, 7); checkOutput("coll hold7", 4'b0001, 2'd0, 1'b1, 1'b0, 4'd7);
    applyStimulus(4'b0010, 1); checkOutput("coll rel",   4'b0010, 2'd1, 1'b1, 1'b0, 4'd0);

    // MAX_HOLD=0 instance never preempts
    doReset();
    req0 = 4'b0011;
    repeat (100) @(negedge clk);
    checkVal("nohold gnt",      32'(gnt0), 32'd1);
    checkVal("nohold hold_cnt", 32'(hc0),  32'd1);
    checkVal("nohold preempts", 32'(pre0_seen), 32'd0);
    req0 = 4'b0000;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter with grant hold and preemption. It shares one resource, such as a memory bank or bus slot, among 4 masters.
- The grant is carried as a 2-bit owner index. A 2-to-4 decoder turns that index into a one-hot grant vector.
- The block sits between requesting masters and the shared resource's address/select logic.

Parameters:
- MAX_HOLD, 8: max consecutive GRANT cycles before the owner is preempted, if another request is pending. 0 disables preemption.
- CNT_W, $clog2(MAX_HOLD+1) (min 1): hold counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request per master; master holds it high while it wants or uses the resource
- gnt  output  4  one-hot grant, decoded from gnt_idx; 4'b0000 when gnt_valid=0
- gnt_idx  output  2  index of current owner
- gnt_valid  output  1  high while a master owns the resource
- preempt  output  1  one-cycle pulse in the cycle a forced handover takes effect
- hold_cnt  output  CNT_W  cycles the current owner has held the grant, 0-based

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; gnt=0; gnt_idx=0; gnt_valid=0; preempt=0; hold_cnt=0.
  - Internal last pointer = 3, so requester 0 has top priority after reset.
  - rst overrides all other inputs and may be asserted mid-grant; the grant drops on the next edge.
- States: IDLE, GRANT. All outputs are registered.
- Priority search:
  - Candidates are scanned from (last+1) mod 4 cyclically; the first requester with req=1 wins.
  - On each new grant, last is set to the winner.
- IDLE:
  - If req!=0 at an edge: go to GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=0. Latency is 1 cycle from sampled req to gnt.
  - If req==0: stay in IDLE.
- GRANT, owner req still high:
  - If MAX_HOLD>0, hold_cnt==MAX_HOLD-1, and any other req is high: preempt.
    - Grant goes to the next requester cyclically after the owner; the owner is excluded even though its req is high.
    - preempt=1 for that cycle; hold_cnt=0.
  - Otherwise hold_cnt increments, saturating at MAX_HOLD-1. With MAX_HOLD=0 it saturates at all-ones.
  - While saturated with no other requester, the owner keeps the grant. Preemption fires at the first cycle another req appears.
- GRANT, owner req low at an edge:
  - Release. If another req is high, it is granted on that same edge (zero-bubble handover, hold_cnt=0, preempt=0).
  - If no other req is high, go to IDLE: gnt_valid=0, gnt=0. gnt_idx keeps its last value.
- Simultaneous events:
  - Owner drops req in the same cycle its timeout would fire: treat as release, not preempt (preempt=0).
  - Multiple new requests in one cycle: round-robin order decides.
- gnt is always one-hot or zero; never more than one bit set.
- A req that rises and falls while another master holds the grant is not remembered.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, GRANT}
  - constant NUM_REQ=4, constant IDX_W=2
  - function next_rr(req, last, exclude) returning the winner index plus a found flag.
- Sub-module: instantiate the team's existing decoder2to4 to drive gnt from gnt_idx, gated by gnt_valid. No other sub-modules.

Test Plan:
- Reset then req=4'b1111 held, MAX_HOLD=8:
  - gnt=0001 one cycle after req.
  - Preempt after 8 grant cycles: gnt=0010 with preempt pulse, then 0100, then 1000, then 0001.
- Single requester req=4'b0100 held for 20 cycles:
  - gnt=0100 throughout, no preempt, hold_cnt saturates at 7.
  - At cycle 20 raise req[0]: next edge gnt=0001, preempt=1.
- Owner release handover, req=0011:
  - Owner 0 granted; drop req[0] after 3 cycles.
  - Next edge gnt=0010, preempt=0, hold_cnt=0; no idle gap.
- Release to empty:
  - req=0001 for 2 cycles then 0000: gnt returns to 0000 and gnt_valid=0 the next edge; state=IDLE.
- Reset mid-grant:
  - req=1000 granted, assert rst at hold_cnt=3: next edge all outputs 0.
  - After rst drops with req=1001, winner is index 0 (pointer reset to 3).
- Timeout/release collision:
  - req=0011, owner 0 drops req exactly at hold_cnt=7: gnt=0010, preempt=0.
  - Repeat with MAX_HOLD=0: owner 0 is never preempted over 100 cycles.
